// File: rtl/fadd_arbiter.sv
`timescale 1ns/1ps
// fadd_arbiter: round-robin front end that shares one fadd core between two
// requesters, one operation in flight at a time. Subtract requests flip the
// sign of operand b before it reaches the core. The core result and its
// INFINITY/NAN flags are captured CORE_LAT edges after the handshake and held
// as a response tagged with the requester id until the consumer takes it.
//
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   reqN_valid/ready         request handshake for requester N (ready is comb)
//   reqN_a, reqN_b, reqN_sub operands and op select (1 = a-b)
//   core_a, core_b           operands to the shared fadd (b sign-adjusted)
//   core_res/inf/nan         fadd result and flags
//   rsp_valid/ready          response handshake
//   rsp_id/res/inf/nan       registered response payload
//   busy                     operation in flight or response pending
module fadd_arbiter #(
  parameter int unsigned CORE_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [31:0] core_res,
  input  logic        core_inf,
  input  logic        core_nan,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_res,
  output logic        rsp_inf,
  output logic        rsp_nan,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(CORE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic               last_grant;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic               op_sub;
  logic               op_id;
  logic [CNT_W-1:0]   cnt;
  logic               grant;
  logic               accept;

  // Round-robin pick: on contention the requester that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is suppressed while reset is high so no requester sees a handshake
  // that the reset would swallow.
  assign req0_ready = (state == IDLE) && !reset && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && !reset && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  // Operands come straight from the op registers so they stay stable in EXEC.
  assign core_a = op_a;
  assign core_b = {op_b[31] ^ op_sub, op_b[30:0]};
  assign busy   = (state != IDLE);

  // Control FSM with operand and response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_sub     <= 1'b0;
      op_id      <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_res    <= '0;
      rsp_inf    <= 1'b0;
      rsp_nan    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= grant ? req1_a : req0_a;
            op_b       <= grant ? req1_b : req0_b;
            op_sub     <= grant ? req1_sub : req0_sub;
            op_id      <= grant;
            last_grant <= grant;
            cnt        <= CNT_W'(CORE_LAT);
            state      <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - CNT_W'(1);
          // Last count: the core output now reflects the launched operands.
          if (cnt == CNT_W'(1)) begin
            rsp_res   <= core_res;
            rsp_inf   <= core_inf;
            rsp_nan   <= core_nan;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_arbiter.sv
`timescale 1ns/1ps
// Bench for fadd_arbiter: one instance with CORE_LAT=1 and one with CORE_LAT=3,
// each driven in turn against a timestamp-based reference model and a
// stand-in fadd core whose output is only correct after CORE_LAT edges.
module tb_fadd_arbiter;

  typedef struct packed {
    logic        r0;
    logic        r1;
    logic [31:0] ca;
    logic [31:0] cb;
    logic        rv;
    logic        rid;
    logic [31:0] rres;
    logic        rinf;
    logic        rnan;
    logic        busy;
  } obs_t;

  logic clk;
  logic rst [2];
  logic v0 [2], v1 [2], s0 [2], s1 [2], rr [2];
  logic [31:0] a0 [2], b0 [2], a1 [2], b1 [2];

  logic        r0_1, r1_1, rv_1, rid_1, rinf_1, rnan_1, busy_1, cinf_1, cnan_1;
  logic [31:0] ca_1, cb_1, rres_1, cres_1;
  logic        r0_3, r1_3, rv_3, rid_3, rinf_3, rnan_3, busy_3, cinf_3, cnan_3;
  logic [31:0] ca_3, cb_3, rres_3, cres_3;
  logic [33:0] pipe1, pipe2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (time-stamped, not cycle-by-cycle FSM)
  bit          m_busy, m_last, m_id, m_sub, m_rid, m_rinf, m_rnan;
  int          m_age;
  logic [31:0] m_a, m_b, m_ca, m_cb, m_rres;

  fadd_arbiter #(.CORE_LAT(1)) u_l1 (
    .clock(clk), .reset(rst[0]),
    .req0_valid(v0[0]), .req0_ready(r0_1), .req0_a(a0[0]), .req0_b(b0[0]), .req0_sub(s0[0]),
    .req1_valid(v1[0]), .req1_ready(r1_1), .req1_a(a1[0]), .req1_b(b1[0]), .req1_sub(s1[0]),
    .core_a(ca_1), .core_b(cb_1), .core_res(cres_1), .core_inf(cinf_1), .core_nan(cnan_1),
    .rsp_valid(rv_1), .rsp_ready(rr[0]), .rsp_id(rid_1), .rsp_res(rres_1),
    .rsp_inf(rinf_1), .rsp_nan(rnan_1), .busy(busy_1));

  fadd_arbiter #(.CORE_LAT(3)) u_l3 (
    .clock(clk), .reset(rst[1]),
    .req0_valid(v0[1]), .req0_ready(r0_3), .req0_a(a0[1]), .req0_b(b0[1]), .req0_sub(s0[1]),
    .req1_valid(v1[1]), .req1_ready(r1_3), .req1_a(a1[1]), .req1_b(b1[1]), .req1_sub(s1[1]),
    .core_a(ca_3), .core_b(cb_3), .core_res(cres_3), .core_inf(cinf_3), .core_nan(cnan_3),
    .rsp_valid(rv_3), .rsp_ready(rr[1]), .rsp_id(rid_3), .rsp_res(rres_3),
    .rsp_inf(rinf_3), .rsp_nan(rnan_3), .busy(busy_3));

  always #5 clk = ~clk;

  // Stand-in fadd: known sums for the directed cases, inf-inf gives NaN,
  // otherwise a sign-sensitive scramble. Returns {nan, inf, res}.
  function automatic logic [33:0] core_fn(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    if (x == 32'h3F80_0000 && y == 32'h4000_0000) return {2'b00, 32'h4040_0000};
    if (x == 32'h4040_0000 && y == 32'hBF80_0000) return {2'b00, 32'h4000_0000};
    if (x[30:23] == 8'hFF && y[30:23] == 8'hFF && x[31] != y[31]) return {2'b10, 32'h7FC0_0000};
    r = x ^ {y[15:0], y[31:16]} ^ 32'h5A5A_0F0F;
    return {r[5] & r[9], r[3] ^ r[7], r};
  endfunction

  assign {cnan_1, cinf_1, cres_1} = core_fn(ca_1, cb_1);

  // Three-edge core: output is stale until two register stages have filled.
  always @(posedge clk) begin
    pipe1 <= core_fn(ca_3, cb_3);
    pipe2 <= pipe1;
  end
  assign {cnan_3, cinf_3, cres_3} = pipe2;

  function automatic obs_t sample(input int d);
    if (d == 0) return {r0_1, r1_1, ca_1, cb_1, rv_1, rid_1, rres_1, rinf_1, rnan_1, busy_1};
    return {r0_3, r1_3, ca_3, cb_3, rv_3, rid_3, rres_3, rinf_3, rnan_3, busy_3};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    x = $urandom;
    if ($urandom_range(3) == 0) x[30:23] = 8'hFF;
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_age = 0; m_id = 0; m_sub = 0;
    m_a = '0; m_b = '0; m_ca = '0; m_cb = '0;
    m_rres = '0; m_rid = 0; m_rinf = 0; m_rnan = 0;
  endtask

  // Async reset with immediate output check; returns just after a rising edge.
  task automatic apply_reset(input int d);
    obs_t o;
    rst[d] = 1'b1;
    #2;
    o = sample(d);
    check("rst_busy", o.busy, 0);
    check("rst_rsp_valid", o.rv, 0);
    check("rst_rsp_res", o.rres, 0);
    check("rst_rsp_id", o.rid, 0);
    check("rst_rsp_inf", o.rinf, 0);
    check("rst_rsp_nan", o.rnan, 0);
    check("rst_core_a", o.ca, 0);
    check("rst_core_b", o.cb, 0);
    check("rst_req0_ready", o.r0, 0);
    check("rst_req1_ready", o.r1, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst[d] = 1'b0;
  endtask

  // One cycle: compare all outputs against the model, then advance past the edge.
  task automatic step(input int d, output bit h0, output bit h1);
    obs_t o;
    int lat;
    bit e0, e1, erv;
    logic [33:0] r;
    lat = (d == 0) ? 1 : 3;
    @(negedge clk);
    if (m_busy && m_age == lat) begin
      r = core_fn(m_a, {m_b[31] ^ m_sub, m_b[30:0]});
      m_rres = r[31:0]; m_rinf = r[32]; m_rnan = r[33]; m_rid = m_id;
    end
    e0  = !m_busy && v0[d] && (!v1[d] || m_last);
    e1  = !m_busy && v1[d] && (!v0[d] || !m_last);
    erv = m_busy && (m_age >= lat);
    o = sample(d);
    check("req0_ready", o.r0, e0);
    check("req1_ready", o.r1, e1);
    check("busy", o.busy, m_busy);
    check("rsp_valid", o.rv, erv);
    check("rsp_id", o.rid, m_rid);
    check("rsp_res", o.rres, m_rres);
    check("rsp_inf", o.rinf, m_rinf);
    check("rsp_nan", o.rnan, m_rnan);
    check("core_a", o.ca, m_ca);
    check("core_b", o.cb, m_cb);
    h0 = v0[d] && o.r0;
    h1 = v1[d] && o.r1;
    if (e0 || e1) begin
      m_busy = 1; m_age = 0; m_id = e1; m_last = e1;
      m_a   = e1 ? a1[d] : a0[d];
      m_b   = e1 ? b1[d] : b0[d];
      m_sub = e1 ? s1[d] : s0[d];
      m_ca  = m_a;
      m_cb  = {m_b[31] ^ m_sub, m_b[30:0]};
    end else if (m_busy) begin
      if (erv && rr[d]) m_busy = 0;
      else m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d);
    bit h0, h1;
    int i;
    v0[d] = 0; v1[d] = 0; rr[d] = 1;
    i = 0;
    while (m_busy && i < 20) begin
      step(d, h0, h1);
      i++;
    end
  endtask

  // Requesters obey the protocol: hold a raised valid until accepted, may drop it early.
  task automatic rand_stim(input int d, input bit g0, input bit g1);
    if (v0[d] && !g0) begin
      if ($urandom_range(7) == 0) v0[d] = 0;
    end else begin
      v0[d] = ($urandom_range(1) == 1);
      a0[d] = rand_fp(); b0[d] = rand_fp(); s0[d] = ($urandom_range(1) == 1);
    end
    if (v1[d] && !g1) begin
      if ($urandom_range(7) == 0) v1[d] = 0;
    end else begin
      v1[d] = ($urandom_range(1) == 1);
      a1[d] = rand_fp(); b1[d] = rand_fp(); s1[d] = ($urandom_range(1) == 1);
    end
    rr[d] = ($urandom_range(3) != 0);
  endtask

  task automatic rand_run(input int d, input int n);
    bit h0, h1;
    h0 = 0; h1 = 0;
    for (int i = 0; i < n; i++) begin
      rand_stim(d, h0, h1);
      step(d, h0, h1);
    end
    drain(d);
  endtask

  // Both requesters always valid: expect alternating grants starting at req0.
  task automatic grant_test(input int d);
    bit h0, h1;
    int lat, prev, k;
    lat = (d == 0) ? 1 : 3;
    prev = -1; k = 0;
    v0[d] = 1; a0[d] = rand_fp(); b0[d] = rand_fp(); s0[d] = 0;
    v1[d] = 1; a1[d] = rand_fp(); b1[d] = rand_fp(); s1[d] = 1;
    rr[d] = 1;
    for (int i = 0; i < 4 * (lat + 2); i++) begin
      step(d, h0, h1);
      if (h0 || h1) begin
        check("t4_grant_id", h1, k % 2);
        if (prev >= 0) check("t4_spacing", i - prev, lat + 2);
        prev = i;
        k++;
      end
    end
    check("t4_handshakes", k, 4);
    drain(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    bit h0, h1, got;
    clk = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1; v0[d] = 0; v1[d] = 0; s0[d] = 0; s1[d] = 0; rr[d] = 0;
      a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
    end
    model_reset();
    @(posedge clk);
    #1;

    // ---------------- CORE_LAT = 1 ----------------
    apply_reset(0);
    step(0, h0, h1);

    v0[0] = 1; a0[0] = 32'h3F80_0000; b0[0] = 32'h4000_0000; s0[0] = 0; rr[0] = 1;
    #1;
    o = sample(0);
    check("t1_req0_ready", o.r0, 1);
    step(0, h0, h1);
    check("t2_handshake", h0, 1);
    v0[0] = 0;
    o = sample(0);
    check("t2_core_b", o.cb, 32'h4000_0000);
    check("t2_rsp_early", o.rv, 0);
    step(0, h0, h1);
    o = sample(0);
    check("t2_rsp_valid", o.rv, 1);
    check("t2_rsp_res", o.rres, 32'h4040_0000);
    check("t2_rsp_id", o.rid, 0);
    step(0, h0, h1);

    v1[0] = 1; a1[0] = 32'h4040_0000; b1[0] = 32'h3F80_0000; s1[0] = 1;
    step(0, h0, h1);
    v1[0] = 0;
    o = sample(0);
    check("t3_core_b", o.cb, 32'hBF80_0000);
    step(0, h0, h1);
    o = sample(0);
    check("t3_rsp_res", o.rres, 32'h4000_0000);
    check("t3_rsp_id", o.rid, 1);
    check("t3_rsp_inf", o.rinf, 0);
    check("t3_rsp_nan", o.rnan, 0);
    step(0, h0, h1);

    grant_test(0);

    // Backpressure in RESP plus inf - inf producing NaN
    v0[0] = 1; a0[0] = 32'h7F80_0000; b0[0] = 32'h7F80_0000; s0[0] = 1; rr[0] = 0;
    step(0, h0, h1);
    v0[0] = 0;
    o = sample(0);
    check("t5_core_b", o.cb, 32'hFF80_0000);
    step(0, h0, h1);
    v0[0] = 1; a0[0] = rand_fp(); b0[0] = rand_fp();
    v1[0] = 1; a1[0] = rand_fp(); b1[0] = rand_fp();
    for (int i = 0; i < 5; i++) begin
      o = sample(0);
      check("t5_rsp_valid", o.rv, 1);
      check("t5_rsp_nan", o.rnan, 1);
      check("t5_rsp_res", o.rres, 32'h7FC0_0000);
      check("t5_req0_ready", o.r0, 0);
      check("t5_req1_ready", o.r1, 0);
      check("t5_busy", o.busy, 1);
      step(0, h0, h1);
    end
    v0[0] = 0; v1[0] = 0; rr[0] = 1;
    step(0, h0, h1);
    o = sample(0);
    check("t5_idle_busy", o.busy, 0);
    check("t5_rsp_dropped", o.rv, 0);
    drain(0);

    rand_run(0, 300);
    rst[0] = 1;

    // ---------------- CORE_LAT = 3 ----------------
    apply_reset(1);
    grant_test(1);
    rand_run(1, 300);

    // Reset in the middle of EXEC: the op is lost and req0 wins next
    v0[1] = 1; a0[1] = rand_fp(); b0[1] = rand_fp(); s0[1] = 0; rr[1] = 1;
    step(1, h0, h1);
    v0[1] = 0;
    step(1, h0, h1);
    o = sample(1);
    check("t6_in_exec", o.busy, 1);
    v0[1] = 1; a0[1] = rand_fp(); b0[1] = rand_fp();
    v1[1] = 1; a1[1] = rand_fp(); b1[1] = rand_fp();
    apply_reset(1);
    got = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, h0, h1);
      if (!got && (h0 || h1)) begin
        check("t6_first_grant", h1, 0);
        got = 1;
      end
    end
    check("t6_granted", got, 1);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
